// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out / echo handshake bundle between uart_word_packer and its neighbours.
// master: the packer side; slave: the uart receiver/transmitter plus the word consumer.
interface uart_word_packer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_sent;

  modport master (
    input  rx_data, rx_valid, word_ready, tx_sent,
    output word_out, word_valid, tx_data, tx_send
  );

  modport slave (
    output rx_data, rx_valid, word_ready, tx_sent,
    input  word_out, word_valid, tx_data, tx_send
  );
endinterface

// File: rtl/uart_word_packer.sv
// Buffers uart bytes in a FIFO and packs them big-endian into 32-bit valid/ready words,
// dropping stale partial words on timeout. Define UART_ECHO_EN to echo each byte to the uart tx.
module uart_word_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                        clk,
  input  logic                        rstn,
  uart_word_packer_if.master          bus,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic                        partial_drop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;

  logic          full, empty, push, pop, echo_idle;
  logic [7:0]    pop_byte;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.rx_valid & ~full;
  assign pop      = (state_q == COLLECT) & ~empty & echo_idle;
  assign pop_byte = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= COLLECT;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    word_d     = word_q;
    valid_d    = valid_q;
    drop_d     = 1'b0;
    ovf_d      = ovf_q;

    // A byte refused while full must win over a same-cycle clear.
    if (clear_ovf)             ovf_d = 1'b0;
    if (bus.rx_valid && full)  ovf_d = 1'b1;

    case (state_q)
      COLLECT: begin
        if (pop) begin
          shift_d  = {shift_q[15:0], pop_byte};
          to_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            word_d     = {shift_q, pop_byte};
            valid_d    = 1'b1;
            byte_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q != '0) begin
          if (to_cnt_q == TO_LAST) begin
            byte_cnt_d = '0;
            shift_d    = '0;
            to_cnt_d   = '0;
            drop_d     = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.word_ready) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign overflow       = ovf_q;
  assign partial_drop   = drop_q;
  assign fifo_count     = count_q;

`ifdef UART_ECHO_EN
  typedef enum logic {ECHO_IDLE, ECHO_BUSY} echo_t;

  echo_t       echo_q, echo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_send_q, tx_send_d;

  assign echo_idle = (echo_q == ECHO_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      echo_q    <= ECHO_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      echo_q    <= echo_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end

  always_comb begin
    echo_d    = echo_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    case (echo_q)
      ECHO_IDLE: begin
        if (pop) begin
          tx_data_d = pop_byte;
          tx_send_d = 1'b1;
          echo_d    = ECHO_BUSY;
        end
      end
      ECHO_BUSY: begin
        if (bus.tx_sent) echo_d = ECHO_IDLE;
      end
      default: echo_d = ECHO_IDLE;
    endcase
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_send = tx_send_q;
`else
  logic unused_tx_sent;

  assign echo_idle      = 1'b1;
  assign bus.tx_data    = '0;
  assign bus.tx_send    = 1'b0;
  assign unused_tx_sent = bus.tx_sent;
`endif

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: expected words/echo bytes are queued as bytes are
// driven and compared when the DUT hands them out. Echo checks apply when UART_ECHO_EN is set.
module tb_uart_word_packer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       overflow, partial_drop;
  logic [4:0] fifo_count;

  uart_word_packer_if bus();

  uart_word_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .partial_drop (partial_drop),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp[$];
  logic [31:0] acc = '0;
  int          acc_n = 0;
  int          hs_cnt = 0, valid_cycles = 0, drop_cnt = 0;
  int          tx_cnt = 0, tx_prev = 0, tx_gap = 0, cyc = 0;
  bit          tx_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    if (accept) begin
      tx_exp.push_back(b);
      acc = {acc[23:0], b};
      acc_n++;
      if (acc_n == 4) begin
        exp_q.push_back(acc);
        acc_n = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!bus.word_valid && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, bus.word_valid, 1'b1);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.word_valid) valid_cycles++;
      if (partial_drop)   drop_cnt++;
      if (bus.tx_send) begin
        tx_seen = 1'b1;
        tx_cnt++;
        tx_gap  = cyc - tx_prev;
        tx_prev = cyc;
`ifdef UART_ECHO_EN
        if (tx_exp.size() == 0) chk("echo_unexpected", tx_exp.size(), 1);
        else                    chk("echo_byte", {24'h0, bus.tx_data}, {24'h0, tx_exp.pop_front()});
`endif
      end
      if (bus.word_valid && bus.word_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("word_unexpected", exp_q.size(), 1);
        else                   chk("word", bus.word_out, exp_q.pop_front());
      end
    end
  end

`ifdef UART_ECHO_EN
  // Uart transmitter stand-in: acknowledges each echo 20 cycles after the request.
  initial begin
    int cd = 0;
    bus.tx_sent = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_sent = 1'b0;
      if (!rstn)            cd = 0;
      else if (bus.tx_send) cd = 20;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) bus.tx_sent = 1'b1;
      end
    end
  end
`else
  initial bus.tx_sent = 1'b0;
`endif

  initial begin
    int hs0, vc0, dc0, t0, k;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.word_ready = 1'b0;

    #12;
    chk("rst_word_out",   bus.word_out, 32'h0);
    chk("rst_word_valid", bus.word_valid, 1'b0);
    chk("rst_fifo_count", fifo_count, 5'd0);
    chk("rst_overflow",   overflow, 1'b0);
    chk("rst_drop",       partial_drop, 1'b0);
    chk("rst_tx_send",    bus.tx_send, 1'b0);
    chk("rst_tx_data",    bus.tx_data, 8'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Single word straight through
    bus.word_ready = 1'b1;
    hs0 = hs_cnt; vc0 = valid_cycles;
    push_byte(8'h12, 1); push_byte(8'h34, 1); push_byte(8'h56, 1); push_byte(8'h78, 1);
    drain("t1_drain", 400);
    idle(3);
    chk("t1_handshakes",  hs_cnt - hs0, 1);
    chk("t1_valid_cycles", valid_cycles - vc0, 1);
    chk("t1_fifo_count",  fifo_count, 5'd0);
    chk("t1_overflow",    overflow, 1'b0);

    // Back-pressure: first word held, second word waits in the FIFO
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1);
    wait_valid("t2_valid", 400);
    idle(2);
    chk("t2_held_word",  bus.word_out, 32'h01020304);
    chk("t2_fifo_count", fifo_count, 5'd4);
    bus.word_ready = 1'b1;
    drain("t2_drain", 400);
    idle(3);
    chk("t2_fifo_empty", fifo_count, 5'd0);

    // Overflow: one word held, 16 bytes fill the FIFO, 17th refused
    bus.word_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i), 1);
    wait_valid("t3_valid", 400);
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i), 1);
    chk("t3_no_ovf_yet", overflow, 1'b0);
    push_byte(8'h40, 0);
    chk("t3_overflow",   overflow, 1'b1);
    chk("t3_fifo_full",  fifo_count, 5'd16);
    chk("t3_held_word",  bus.word_out, 32'h20212223);
    clear_ovf = 1'b1;
    push_byte(8'h41, 0);
    clear_ovf = 1'b0;
    chk("t3_set_wins",   overflow, 1'b1);
    clear_ovf = 1'b1;
    idle(1);
    clear_ovf = 1'b0;
    chk("t3_cleared",    overflow, 1'b0);
    bus.word_ready = 1'b1;
    drain("t3_drain", 2000);
    idle(3);
    chk("t3_fifo_empty", fifo_count, 5'd0);

    // Timeout drops a stale partial word
    dc0 = drop_cnt;
    push_byte(8'hAA, 1); push_byte(8'hBB, 1);
    idle(90);
    chk("t4_no_early_drop", drop_cnt - dc0, 0);
    k = 0;
    while (drop_cnt == dc0 && k < 150) begin
      @(posedge clk); #1;
      k++;
    end
    idle(5);
    chk("t4_drop_pulses", drop_cnt - dc0, 1);
    acc = '0; acc_n = 0;
    push_byte(8'h11, 1); push_byte(8'h22, 1); push_byte(8'h33, 1); push_byte(8'h44, 1);
    drain("t4_drain", 400);
    idle(3);
    chk("t4_word_kept", bus.word_out, 32'h11223344);

    // Asynchronous reset mid-word
    push_byte(8'h9A, 1); push_byte(8'hBC, 1); push_byte(8'hDE, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_word_out",   bus.word_out, 32'h0);
    chk("t5_word_valid", bus.word_valid, 1'b0);
    chk("t5_fifo_count", fifo_count, 5'd0);
    chk("t5_overflow",   overflow, 1'b0);
    exp_q.delete(); tx_exp.delete();
    acc = '0; acc_n = 0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    push_byte(8'hDE, 1); push_byte(8'hAD, 1); push_byte(8'hBE, 1); push_byte(8'hEF, 1);
    drain("t5_drain", 400);
    idle(3);
    chk("t5_fifo_empty", fifo_count, 5'd0);

`ifdef UART_ECHO_EN
    // Second pop waits for the uart acknowledge
    t0 = tx_cnt;
    push_byte(8'h5A, 1); push_byte(8'hC3, 1);
    k = 0;
    while (tx_cnt < t0 + 2 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("echo_count", tx_cnt - t0, 2);
    chk("echo_gap_ok", (tx_gap >= 20 && tx_gap <= 24), 1'b1);
    chk("echo_last_byte", bus.tx_data, 8'hC3);
`else
    t0 = 0;
    chk("tx_send_quiet", tx_seen, 1'b0);
    chk("tx_data_zero",  bus.tx_data, 8'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
